// File: rtl/mems_spi_pkg.sv
// Shared constants for the MEMS mirror SPI link (transmitter and receiver).
// Frame width, SPI mode and receiver state encoding live here so both ends agree.
package mems_spi_pkg;

    localparam int MEMS_SPI_DATA_W = 24;

    // SPI mode 1: SCK idles low, data launched on rise, sampled on fall.
    localparam logic MEMS_SPI_CPOL = 1'b0;
    localparam logic MEMS_SPI_CPHA = 1'b1;
    localparam logic [1:0] MEMS_SPI_MODE = {MEMS_SPI_CPOL, MEMS_SPI_CPHA};

    localparam logic [1:0] WAIT_CS_HIGH = 2'd0;
    localparam logic [1:0] IDLE         = 2'd1;
    localparam logic [1:0] RECV         = 2'd2;

endpackage

// File: rtl/mems_spi_slave_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses.
// level is delayed one extra flop so it lines up with the edge pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic              rise_reg;
    logic              fall_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_reg[gi] <= RST_VAL;
                end else if (gi == 0) begin
                    sync_reg[gi] <= din;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_reg <= RST_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[STAGES-1];
            rise_reg <= sync_reg[STAGES-1] & ~prev_reg;
            fall_reg <= ~sync_reg[STAGES-1] & prev_reg;
        end
    end

    assign level = prev_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/mems_spi_slave.sv
// Oversampling SPI mode-1 receiver for the MEMS mirror command link.
// Receives MSB-first frames on MOSI and returns a latched status word on MISO.
module mems_spi_slave
    import mems_spi_pkg::*;
#(
    parameter int DATA_W      = MEMS_SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sck,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic [DATA_W-1:0] data_out,
    output logic              new_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int                CNT_W      = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DATA_W + 1);
    localparam int                SETTLE_W   = $clog2(SYNC_STAGES + 3);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 2);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [1:0]          state_reg, state_next;
    logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0]   tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0]   data_out_reg, data_out_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;
    logic                first_rise_reg, first_rise_next;
    logic                miso_reg, miso_next;
    logic                new_data_reg, new_data_next;
    logic                frame_err_reg, frame_err_next;

    always_comb begin
        state_next      = state_reg;
        rx_shift_next   = rx_shift_reg;
        tx_shift_next   = tx_shift_reg;
        data_out_next   = data_out_reg;
        bit_cnt_next    = bit_cnt_reg;
        first_rise_next = first_rise_reg;
        miso_next       = miso_reg;
        new_data_next   = 1'b0;
        frame_err_next  = 1'b0;
        // The synchronizers come out of reset reading "cs high"; trust cs only once the real pin has propagated.
        settle_next     = (settle_reg == SETTLE_MAX) ? settle_reg : settle_reg + SETTLE_W'(1);

        case (state_reg)
            WAIT_CS_HIGH: begin
                miso_next = 1'b0;
                if (settle_reg == SETTLE_MAX && cs_level) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                miso_next = 1'b0;
                if (cs_fall) begin
                    bit_cnt_next    = '0;
                    tx_shift_next   = tx_data;
                    miso_next       = tx_data[DATA_W-1];
                    first_rise_next = 1'b1;
                    state_next      = RECV;
                end
            end
            RECV: begin
                if (sck_fall) begin
                    rx_shift_next = {rx_shift_reg[DATA_W-2:0], mosi_level};
                    bit_cnt_next  = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + CNT_W'(1);
                end
                // The MSB is already on miso from cs_fall, so the first rise only arms shifting.
                if (sck_rise) begin
                    if (first_rise_reg) begin
                        first_rise_next = 1'b0;
                    end else begin
                        tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
                        miso_next     = tx_shift_reg[DATA_W-2];
                    end
                end
                // Uses the *_next values so a coincident final sck_fall is counted before closing.
                if (cs_rise) begin
                    if (bit_cnt_next == CNT_FULL) begin
                        data_out_next = rx_shift_next;
                        new_data_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    miso_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                miso_next  = 1'b0;
                state_next = WAIT_CS_HIGH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= WAIT_CS_HIGH;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            data_out_reg   <= '0;
            bit_cnt_reg    <= '0;
            settle_reg     <= '0;
            first_rise_reg <= 1'b0;
            miso_reg       <= 1'b0;
            new_data_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rx_shift_reg   <= rx_shift_next;
            tx_shift_reg   <= tx_shift_next;
            data_out_reg   <= data_out_next;
            bit_cnt_reg    <= bit_cnt_next;
            settle_reg     <= settle_next;
            first_rise_reg <= first_rise_next;
            miso_reg       <= miso_next;
            new_data_reg   <= new_data_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign miso      = miso_reg;
    assign data_out  = data_out_reg;
    assign new_data  = new_data_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == RECV);

endmodule

// File: tb/tb_mems_spi_slave.sv
// Directed bench for mems_spi_slave: an inline SPI mode-1 master with 8/8 clk SCK phases.
module tb_mems_spi_slave;

    localparam int DATA_W      = 24;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs;
    logic              sck;
    logic              mosi;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic [DATA_W-1:0] data_out;
    logic              new_data;
    logic              frame_err;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int nd_cnt    = 0;
    int fe_cnt    = 0;
    logic [DATA_W-1:0] rx_q[$];

    always #5 clk = ~clk;

    mems_spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi),
        .tx_data(tx_data), .miso(miso), .data_out(data_out),
        .new_data(new_data), .frame_err(frame_err), .busy(busy)
    );

    // Pulse monitor: logs every strobe and checks the two strobes never coincide.
    always @(negedge clk) begin
        if (new_data) begin
            nd_cnt++;
            rx_q.push_back(data_out);
        end
        if (frame_err) fe_cnt++;
        if (new_data || frame_err) begin
            total_cnt++;
            if (new_data && frame_err)
                $display("FAIL strobe_overlap: new_data=%b frame_err=%b required not both", new_data, frame_err);
            else
                pass_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_open();
        cs = 1'b0;
        wait_cyc(HALF);
    endtask

    // Master launches mosi on SCK rise and captures miso on SCK fall.
    task automatic send_bits(input logic [31:0] word, input int nbits, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b1;
            mosi = word[nbits-1-i];
            wait_cyc(HALF);
            sck = 1'b0;
            got = {got[30:0], miso};
            wait_cyc(HALF);
        end
    endtask

    task automatic frame_close();
        cs = 1'b0;
        cs = 1'b1;
        wait_cyc(12);
    endtask

    task automatic test_reset();
        rst = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = '0;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(1);
        total_cnt += 5;
        if (data_out !== 24'h0) $display("FAIL reset_data_out: got %h want %h", data_out, 24'h0); else pass_cnt++;
        if (new_data !== 1'b0) $display("FAIL reset_new_data: got %b want 0", new_data); else pass_cnt++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else pass_cnt++;
        wait_cyc(10);
        $display("reset: done");
    endtask

    task automatic test_single();
        int nd0, fe0, lat;
        logic [31:0] got;
        nd0 = nd_cnt; fe0 = fe_cnt;
        frame_open();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy_in_frame: got %b want 1", busy); else pass_cnt++;
        send_bits(32'h00A5C30F, DATA_W, got);
        cs  = 1'b1;
        lat = 0;
        while (new_data !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat != SYNC_STAGES + 2) $display("FAIL single_latency: got %0d want %0d", lat, SYNC_STAGES + 2); else pass_cnt++;
        wait_cyc(10);
        total_cnt += 4;
        if (data_out !== 24'hA5C30F) $display("FAIL single_data: got %h want %h", data_out, 24'hA5C30F); else pass_cnt++;
        if (nd_cnt - nd0 != 1) $display("FAIL single_new_data_count: got %0d want 1", nd_cnt - nd0); else pass_cnt++;
        if (fe_cnt != fe0) $display("FAIL single_frame_err_count: got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else pass_cnt++;
        $display("single: data_out=%h latency=%0d", data_out, lat);
    endtask

    task automatic test_abort();
        int nd0, fe0;
        logic [31:0] got;
        nd0 = nd_cnt; fe0 = fe_cnt;
        frame_open();
        send_bits(32'h007FFFFF, 23, got);
        frame_close();
        total_cnt += 3;
        if (fe_cnt - fe0 != 1) $display("FAIL abort_frame_err_count: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        if (nd_cnt != nd0) $display("FAIL abort_new_data_count: got %0d want 0", nd_cnt - nd0); else pass_cnt++;
        if (data_out !== 24'hA5C30F) $display("FAIL abort_data_held: got %h want %h", data_out, 24'hA5C30F); else pass_cnt++;
        $display("abort: 23 bits, data_out=%h", data_out);
    endtask

    task automatic test_overrun();
        int nd0, fe0;
        logic [31:0] got;
        nd0 = nd_cnt; fe0 = fe_cnt;
        frame_open();
        send_bits(32'h01555555, 25, got);
        frame_close();
        total_cnt += 3;
        if (fe_cnt - fe0 != 1) $display("FAIL overrun_frame_err_count: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        if (nd_cnt != nd0) $display("FAIL overrun_new_data_count: got %0d want 0", nd_cnt - nd0); else pass_cnt++;
        if (data_out !== 24'hA5C30F) $display("FAIL overrun_data_held: got %h want %h", data_out, 24'hA5C30F); else pass_cnt++;
        $display("overrun: 25 bits, data_out=%h", data_out);
    endtask

    task automatic test_back_to_back();
        int nd0, q0;
        logic [31:0] got;
        nd0 = nd_cnt; q0 = rx_q.size();
        frame_open();
        send_bits(32'h00000001, DATA_W, got);
        cs = 1'b1;
        wait_cyc(4);
        frame_open();
        send_bits(32'h00FFFFFE, DATA_W, got);
        frame_close();
        total_cnt += 3;
        if (nd_cnt - nd0 != 2) $display("FAIL b2b_new_data_count: got %0d want 2", nd_cnt - nd0); else pass_cnt++;
        if (rx_q.size() < q0 + 2) begin
            $display("FAIL b2b_words: got %0d words want 2", rx_q.size() - q0);
        end else begin
            if (rx_q[q0] !== 24'h000001) $display("FAIL b2b_first: got %h want %h", rx_q[q0], 24'h000001); else pass_cnt++;
            if (rx_q[q0+1] !== 24'hFFFFFE) $display("FAIL b2b_second: got %h want %h", rx_q[q0+1], 24'hFFFFFE); else pass_cnt++;
        end
        $display("back_to_back: data_out=%h", data_out);
    endtask

    task automatic test_miso();
        logic [31:0] got_a, got_b;
        tx_data = 24'h123456;
        frame_open();
        send_bits(32'h00000555, 4, got_a);
        tx_data = 24'h000000;
        send_bits(32'h00555555, 20, got_b);
        frame_close();
        total_cnt += 2;
        if ({got_a[3:0], got_b[19:0]} !== 24'h123456)
            $display("FAIL miso_capture: got %h want %h", {got_a[3:0], got_b[19:0]}, 24'h123456);
        else pass_cnt++;
        if (data_out !== 24'h555555) $display("FAIL miso_frame_data: got %h want %h", data_out, 24'h555555); else pass_cnt++;
        $display("miso: master captured %h", {got_a[3:0], got_b[19:0]});
    endtask

    task automatic test_reset_mid_frame();
        int nd0, fe0;
        logic [31:0] got;
        nd0 = nd_cnt; fe0 = fe_cnt;
        frame_open();
        send_bits(32'h000003FF, 10, got);
        rst = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        send_bits(32'h00003FFF, 14, got);
        frame_close();
        total_cnt += 3;
        if (nd_cnt != nd0) $display("FAIL rstmid_new_data_count: got %0d want 0", nd_cnt - nd0); else pass_cnt++;
        if (fe_cnt != fe0) $display("FAIL rstmid_frame_err_count: got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        if (data_out !== 24'h000000) $display("FAIL rstmid_data: got %h want %h", data_out, 24'h000000); else pass_cnt++;
        frame_open();
        send_bits(32'h000ABCDE, DATA_W, got);
        frame_close();
        total_cnt += 2;
        if (nd_cnt - nd0 != 1) $display("FAIL rstmid_next_count: got %0d want 1", nd_cnt - nd0); else pass_cnt++;
        if (data_out !== 24'h0ABCDE) $display("FAIL rstmid_next_data: got %h want %h", data_out, 24'h0ABCDE); else pass_cnt++;
        $display("reset_mid_frame: next data_out=%h", data_out);
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_overrun();
        test_back_to_back();
        test_miso();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
